// File: rtl/dm_ctrl.sv
// Data-memory controller: valid/ready request, one-cycle response pulse, byte/half/word access, RD_LAT 1..4.
// Optional store trace compiled in with `define DM_CTRL_TRACE_EN.
module dm_ctrl #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0]  CNT_LAST = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    if (RD_LAT == 0 || RD_LAT > 4) begin : g_bad_rd_lat
        $fatal(1, "dm_ctrl: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hold_q;
    logic        we_q, err_q, uns_q;
    logic [1:0]  size_q, lane_q;

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    logic [31:0]      off;
    logic [29:0]      off_word;
    logic             oor;
    logic             fault;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cur_word;
    logic [3:0]       be;
    logic [31:0]      wd_rep;
    logic [31:0]      merged;
    logic             accept;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ld_data;
    logic             unused_ok;

    // Request decode: address below base or past the last word is out of range.
    assign off      = req_addr - BASE_ADDR;
    assign off_word = off[31:2];
    assign oor      = (req_addr < BASE_ADDR) || (off_word >= 30'(DEPTH_WORDS));
    assign idx      = off_word[IDX_W-1:0];
    assign cur_word = oor ? '0 : mem_q[idx];
    assign accept   = req_valid && req_ready && reset;

    always_comb begin
        fault = oor;
        case (req_size)
            2'b00:   ;
            2'b01:   if (req_addr[0]) fault = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) fault = 1'b1;
            default: fault = 1'b1;
        endcase
    end

    always_comb begin
        be     = 4'b1111;
        wd_rep = req_wdata;
        case (req_size)
            2'b00: begin
                be     = 4'b0001 << req_addr[1:0];
                wd_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be     = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        merged = cur_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
        end
    end

    // The array has no reset so a store committed on its accept edge survives a later reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) mem_q[idx] <= merged;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (req_we || fault || RD_LAT == 1) state_d = RESP;
                    else                                state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                hold_q <= cur_word;
                we_q   <= req_we;
                err_q  <= fault;
                uns_q  <= req_unsigned;
                size_q <= req_size;
                lane_q <= req_addr[1:0];
            end
        end
    end

    assign byte_sel = 8'(hold_q >> {lane_q, 3'b000});
    assign half_sel = lane_q[1] ? hold_q[31:16] : hold_q[15:0];

    always_comb begin
        case (size_q)
            2'b00:   ld_data = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   ld_data = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: ld_data = hold_q;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = (state_q == RESP && !we_q && !err_q) ? ld_data : '0;

`ifdef DM_CTRL_TRACE_EN
    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            if (fault) $display("%d@%h: DM fault %h", $time, req_pc, req_addr);
            else       $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
        end
    end
    assign unused_ok = ^off[1:0];
`else
    assign unused_ok = ^{off[1:0], req_pc};
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed scoreboard bench for dm_ctrl with RD_LAT=3.
module tb_dm_ctrl;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    dm_ctrl #(
        .DEPTH_WORDS(3072),
        .BASE_ADDR  (32'h0000_0000),
        .RD_LAT     (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_pc      (req_pc),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response pulse.
    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        exp_t        e;
        exp_t        got;
        int unsigned k;
        bit          seen;
        e.tag   = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = (we || exp_err) ? 1 : LAT;
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = req_pc + 32'd4;
        sb.push_back(e);
        @(posedge clk);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            // Stalled junk store to a live word; must be ignored while not ready.
            req_we    = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'hDEAD_BEEF;
            if (rsp_valid === 1'b1) seen = 1'b1;
            else check({tag, "/stall_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check({tag, "/rsp_seen"}, 32'(seen), 32'd1);
        got = sb.pop_front();
        if (seen) begin
            check({got.tag, "/latency"}, 32'(k), 32'(got.lat));
            check({got.tag, "/rdata"}, rsp_rdata, got.rdata);
            check({got.tag, "/err"}, 32'(rsp_err), 32'(got.err));
            check({got.tag, "/busy_rsp"}, 32'(busy), 32'd1);
            check({got.tag, "/ready_rsp"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        check({tag, "/pulse_end"}, 32'(rsp_valid), 32'd0);
        check({tag, "/idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0010;
        req_wdata    = '0;
        req_pc       = 32'h0000_1000;

        repeat (3) @(negedge clk);
        check("rst/ready", 32'(req_ready), 32'd1);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/rdata", rsp_rdata, 32'd0);
        check("rst/err", 32'(rsp_err), 32'd0);
        reset = 1'b1;

        xact("sw_10",   1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0000_0000, 1'b0);
        xact("lb_13",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h0000_0012, 1'b0);
        xact("lhu_10",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'h0000_5678, 1'b0);
        xact("lh_12",   1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h0000_1234, 1'b0);

        xact("lw_20a",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h0000_0000, 1'b0);
        xact("sb_21",   1'b1, 2'b00, 1'b0, 32'h21, 32'hABCD_EFF0, 32'h0000_0000, 1'b0);
        xact("lw_20b",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h0000_F000, 1'b0);
        xact("lb_21",   1'b0, 2'b00, 1'b0, 32'h21, 32'h0,         32'hFFFF_FFF0, 1'b0);
        xact("lbu_21",  1'b0, 2'b00, 1'b1, 32'h21, 32'h0,         32'h0000_00F0, 1'b0);
        xact("sh_22",   1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, 32'h0000_0000, 1'b0);
        xact("lw_20c",  1'b0, 2'b10, 1'b1, 32'h20, 32'h0,         32'hBEEF_F000, 1'b0);
        xact("lh_22",   1'b0, 2'b01, 1'b0, 32'h22, 32'h0,         32'hFFFF_BEEF, 1'b0);
        xact("lhu_22",  1'b0, 2'b01, 1'b1, 32'h22, 32'h0,         32'h0000_BEEF, 1'b0);

        xact("lw_mis6", 1'b0, 2'b10, 1'b0, 32'h06,   32'h0,         32'h0, 1'b1);
        xact("sh_mis3", 1'b1, 2'b01, 1'b0, 32'h03,   32'hFFFF_FFFF, 32'h0, 1'b1);
        xact("ld_sz11", 1'b0, 2'b11, 1'b0, 32'h10,   32'h0,         32'h0, 1'b1);
        xact("st_sz11", 1'b1, 2'b11, 1'b0, 32'h20,   32'h5555_5555, 32'h0, 1'b1);
        xact("sw_oor",  1'b1, 2'b10, 1'b0, 32'h3000, 32'h7777_7777, 32'h0, 1'b1);
        xact("lw_oor",  1'b0, 2'b10, 1'b0, 32'h3000, 32'h0,         32'h0, 1'b1);
        xact("lw_00",   1'b0, 2'b10, 1'b0, 32'h00,   32'h0,         32'h0000_0000, 1'b0);
        xact("lw_10",   1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         32'h1234_5678, 1'b0);
        xact("lw_20d",  1'b0, 2'b10, 1'b0, 32'h20,   32'h0,         32'hBEEF_F000, 1'b0);

        xact("sw_last", 1'b1, 2'b10, 1'b0, 32'h2FFC, 32'hCAFE_F00D, 32'h0, 1'b0);
        xact("lw_last", 1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0,         32'hCAFE_F00D, 1'b0);

        xact("sw_40",   1'b1, 2'b10, 1'b0, 32'h40, 32'h0BAD_F00D, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid/busy_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid/rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid/busy", 32'(busy), 32'd0);
        check("mid/ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < int'(LAT) + 1; i++) begin
            @(negedge clk);
            check("mid/no_rsp", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        xact("lw_40",   1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
